// File: rtl/phy_pd_defs.sv
// phy_pd_defs: CRC-32 constants, framer state encoding and the one-nibble CRC step
package phy_pd_defs;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  typedef enum logic [2:0] {IDLE, DATA_LO, DATA_HI, WAIT, CRC} tx_state_t;
  function automatic logic [31:0] crc32_nib_step(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc ^ {28'h0, nib};
    for (int i = 0; i < 4; i++) c = c[0] ? (c >> 1) ^ CRC32_POLY_REFL : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/phy_tx_crc32_engine.sv
// phy_tx_crc32_engine: reflected CRC-32 register folding one nibble per enabled cycle
module phy_tx_crc32_engine
  import phy_pd_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [3:0]  nib,
  output logic [31:0] crc
);
  // init wins over a fold; nothing changes otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= '0;
    else if (init) crc <= CRC32_INIT;
    else if (en) crc <= crc32_nib_step(crc, nib);
endmodule

// File: rtl/phy_tx_crc_framer.sv
// phy_tx_crc_framer: splits payload bytes into nibbles (low first) and appends the CRC-32
module phy_tx_crc_framer
  import phy_pd_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_nib,
  output logic        out_last,
  output logic        pkt_done,
  output logic [31:0] crc_value
);
  tx_state_t state, state_nxt;
  logic [7:0] byte_q;
  logic last_q;
  logic [31:0] crc, shift;
  logic [2:0] cnt;
  logic accept, hs, enter_crc;
  assign accept = in_valid && in_ready && !abort;
  assign hs = out_valid && out_ready && !abort;
  assign enter_crc = hs && state == DATA_HI && last_q;
  phy_tx_crc32_engine u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (accept && state == IDLE),
    .en    (hs && (state == DATA_LO || state == DATA_HI)),
    .nib   (out_nib),
    .crc   (crc)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state and handshake outputs; abort forces IDLE over any handshake
  always_comb begin
    state_nxt = state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    out_nib = '0;
    out_last = 1'b0;
    case (state)
      IDLE, WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DATA_LO;
      end
      DATA_LO: begin
        out_valid = 1'b1;
        out_nib = byte_q[3:0];
        if (out_ready) state_nxt = DATA_HI;
      end
      DATA_HI: begin
        out_valid = 1'b1;
        out_nib = byte_q[7:4];
        in_ready = out_ready && !last_q;
        if (out_ready) state_nxt = last_q ? CRC : in_valid ? DATA_LO : WAIT;
      end
      CRC: begin
        out_valid = 1'b1;
        out_nib = shift[3:0];
        out_last = cnt == 3'd7;
        if (out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end
  // byte latch, CRC shift-out, completion pulse and reported CRC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      byte_q <= '0;
      last_q <= 1'b0;
      shift <= '0;
      cnt <= '0;
      pkt_done <= 1'b0;
      crc_value <= '0;
    end else begin
      pkt_done <= hs && out_last;
      if (accept) begin
        byte_q <= in_data;
        last_q <= in_last;
      end
      if (enter_crc) begin
        shift <= ~crc32_nib_step(crc, byte_q[7:4]);
        cnt <= '0;
      end else if (hs && state == CRC) begin
        shift <= shift >> 4;
        cnt <= cnt + 3'd1;
      end
      if (hs && out_last) crc_value <= ~crc;
    end
endmodule

// File: doc/phy_tx_crc_framer.md
PHY_TX_CRC_FRAMER -- requirements
Module: phy_tx_crc_framer

Interface
REQ-001 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  payload byte offered.
REQ-004 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-005 SHALL have port in_data  input  8  payload byte.
REQ-006 SHALL have port in_last  input  1  qualifies in_data as the final payload byte.
REQ-007 SHALL have port abort  input  1  synchronous packet abort.
REQ-008 SHALL have port out_valid  output  1  nibble offered to the 4b5b encoder.
REQ-009 SHALL have port out_ready  input  1  nibble consumed when out_valid && out_ready.
REQ-010 SHALL have port out_nib  output  4  data or CRC nibble.
REQ-011 SHALL have port out_last  output  1  marks the final CRC nibble.
REQ-012 SHALL have port pkt_done  output  1  one-cycle pulse after the final nibble handshake.
REQ-013 SHALL have port crc_value  output  32  transmitted CRC, held from pkt_done until the next packet start.

Function
REQ-014 SHALL implement states IDLE, DATA_LO, DATA_HI, WAIT, CRC.
REQ-015 IDLE: in_ready=1, out_valid=0; on accept, latch byte and in_last, init CRC register to 0xFFFFFFFF, go to DATA_LO.
REQ-016 DATA_LO: out_valid=1, out_nib=byte[3:0]; on handshake, fold nibble into CRC and go to DATA_HI.
REQ-017 DATA_HI: out_nib=byte[7:4]; in_ready = out_ready && !last_flag (combinational).
REQ-018 DATA_HI handshake: fold nibble; last_flag set -> CRC; else byte accepted same cycle -> DATA_LO; else -> WAIT.
REQ-019 WAIT: in_ready=1, out_valid=0; CRC register retained (no re-init); on accept, go to DATA_LO.
REQ-020 Entering CRC: snapshot ~crc_reg into 32-bit shift register and clear nibble counter.
REQ-021 CRC: out_nib=shift[3:0]; on each handshake shift right 4 and increment the counter; out_last=1 when counter==7.
REQ-022 CRC handshake at counter 7: go to IDLE, pulse pkt_done, load crc_value.
REQ-023 CRC fold: reflected polynomial 0xEDB88320, nibble LSB first, four bit-steps per nibble, i.e. one nibble per cycle.
REQ-024 Latency: the first data nibble is valid the cycle after byte accept; the first CRC nibble is valid the cycle after the last high-nibble handshake.
REQ-025 out_nib and out_last SHALL hold stable while out_valid && !out_ready.
REQ-026 Abort in any state: next state IDLE, out_valid=0 next cycle, no pkt_done, crc_value unchanged; abort overrides a same-cycle input or output handshake.
REQ-027 A zero-length packet is not supported: a packet always starts with an accepted byte.

Reset
REQ-028 On rst_n low: state IDLE, in_ready=1, out_valid=0, out_nib=0, out_last=0, pkt_done=0, crc_value=0, CRC/shift/counter registers=0.
REQ-029 A reset mid-packet SHALL discard the packet with no pkt_done.

Structure
REQ-030 Shared package phy_pd_defs SHALL hold CRC32_POLY_REFL (0xEDB88320), CRC32_INIT (0xFFFFFFFF), the state encoding and the nibble-step function.
REQ-031 CRC register plus step logic SHALL be one sub-module phy_tx_crc32_engine (inputs init, en, nib; output crc).

Verification
REQ-032 Payload "123456789" (0x31..0x39, last on 0x39), out_ready=1 -> 18 nibbles 1,3,2,3,...,9,3, then 6,2,9,3,4,F,B,C; crc_value=0xCBF43926.
REQ-033 Single byte 0x00 -> 0,0,D,8,F,E,2,0,2,D; out_last only on the tenth nibble; pkt_done one cycle later.
REQ-034 Random out_ready stalls on vector REQ-032 -> identical nibble sequence, no nibble changes while stalled.
REQ-035 in_valid gaps between bytes (WAIT visits) -> CRC still 0xCBF43926.
REQ-036 Abort during CRC counter 3 -> out_valid=0 next cycle, no pkt_done; next packet 0x00 -> CRC 0xD202EF8D.
REQ-037 rst_n asserted in DATA_HI -> all outputs at reset values asynchronously.
